// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the FIFO read-side controller.
package fifo_pkg;

   localparam int DELAY_MIN = 1;
   localparam int DELAY_MAX = 4;

   function automatic int ptr_width(input int addw);
      return addw + 1;
   endfunction

   // Enough room for every in-flight word plus one word being consumed.
   function automatic int obuf_depth(input int delay);
      return delay + 2;
   endfunction

endpackage

// File: rtl/fifo_obuf.sv
// Small register FIFO holding returned read data; depth need not be a power of two.
module fifo_obuf #(
   parameter int DEPTH = 3,
   parameter int DATW  = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         push,
   input  logic [DATW-1:0]              din,
   input  logic                         pop,
   output logic [DATW-1:0]              head,
   output logic                         vld,
   output logic [$clog2(DEPTH+1)-1:0]   cnt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DATW-1:0] mem_q [DEPTH];
   logic [DATW-1:0] mem_d [DEPTH];
   logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      mem_d = mem_q;
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (clr) begin
         wp_d  = '0;
         rp_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) begin
            mem_d[wp_q] = din;
            wp_d        = ptr_inc(wp_q);
         end
         if (pop) rp_d = ptr_inc(rp_q);
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   assign head = mem_q[rp_q];
   assign vld  = (cnt_q != '0);
   assign cnt  = cnt_q;

endmodule

// File: rtl/fifomem.sv
// Dual-port FIFO storage with a DELAY-cycle registered read path.
module fifomem #(
   parameter int ADDW  = 4,
   parameter int DATW  = 8,
   parameter int DELAY = 1
) (
   input  logic            clk,
   input  logic            wen,
   input  logic [ADDW-1:0] wadd,
   input  logic [DATW-1:0] wdata,
   input  logic [ADDW-1:0] radd,
   output logic [DATW-1:0] rdata
);

   logic [DATW-1:0] mem_q  [2**ADDW];
   logic [DATW-1:0] pipe_q [DELAY];

   always_ff @(posedge clk) begin
      if (wen) mem_q[wadd] <= wdata;
      pipe_q[0] <= mem_q[radd];
      for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
   end

   assign rdata = pipe_q[DELAY-1];

endmodule

// File: rtl/fifo_rdctl.sv
// FIFO read-side controller: issues memory reads against a credit limit and
// presents returned words as a first-word-fall-through valid/ready stream.
module fifo_rdctl
   import fifo_pkg::*;
#(
   parameter int ADDW  = 4,
   parameter int DATW  = 8,
   parameter int DELAY = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic [ADDW:0]   wptr,
   output logic [ADDW:0]   rptr,
   output logic [ADDW-1:0] radd,
   input  logic [DATW-1:0] rdata,
   output logic [DATW-1:0] dout,
   output logic            dout_vld,
   input  logic            dout_rdy,
   output logic            empty
);

   localparam int PTRW = ptr_width(ADDW);
   localparam int OBD  = obuf_depth(DELAY);
   localparam int CNTW = $clog2(OBD + 1);
   localparam logic [CNTW:0] OBD_LIM = (CNTW + 1)'(OBD);

   generate
      if (DELAY < DELAY_MIN || DELAY > DELAY_MAX) begin : g_bad_delay
         $error("fifo_rdctl: DELAY out of supported range");
      end
   endgenerate

   logic [PTRW-1:0]  rptr_q, rptr_d;
   logic [DELAY-1:0] vld_q, vld_d;
   logic [CNTW-1:0]  infl, obcnt;
   logic             mem_ne, issue, push, pop;

   always_comb begin
      infl = '0;
      for (int i = 0; i < DELAY; i++) infl = infl + CNTW'(vld_q[i]);
   end

   // The current pop is not credited, keeping dout_rdy off the issue path.
   assign mem_ne = (rptr_q != wptr);
   assign issue  = mem_ne & ~clr & (({1'b0, infl} + {1'b0, obcnt}) < OBD_LIM);
   assign push   = vld_q[DELAY-1] & ~clr;
   assign pop    = dout_vld & dout_rdy & ~clr;

   always_comb begin
      rptr_d = rptr_q;
      vld_d  = '0;
      if (clr) begin
         rptr_d = wptr;
      end else begin
         if (issue) rptr_d = rptr_q + 1'b1;
         vld_d[0] = issue;
         for (int i = 1; i < DELAY; i++) vld_d[i] = vld_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rptr_q <= '0;
         vld_q  <= '0;
      end else begin
         rptr_q <= rptr_d;
         vld_q  <= vld_d;
      end
   end

   fifo_obuf #(
      .DEPTH (OBD),
      .DATW  (DATW)
   ) u_obuf (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .push  (push),
      .din   (rdata),
      .pop   (pop),
      .head  (dout),
      .vld   (dout_vld),
      .cnt   (obcnt)
   );

   assign rptr  = rptr_q;
   assign radd  = rptr_q[ADDW-1:0];
   assign empty = ~mem_ne & (infl == '0) & (obcnt == '0);

endmodule

// File: tb/tb_fifo_rdctl.sv
// Directed bench for fifo_rdctl driving the write side of fifomem by hand.
module tb_fifo_rdctl;

   localparam int ADDW  = 4;
   localparam int DATW  = 8;
   localparam int DELAY = 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            clr = 1'b0;
   logic            wen = 1'b0;
   logic            dout_rdy = 1'b0;
   logic [ADDW:0]   wptr = '0;
   logic [ADDW-1:0] wadd = '0;
   logic [DATW-1:0] wdata = '0;
   logic [ADDW:0]   rptr;
   logic [ADDW-1:0] radd;
   logic [DATW-1:0] rdata, dout;
   logic            dout_vld, empty;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fifomem #(.ADDW(ADDW), .DATW(DATW), .DELAY(DELAY)) u_mem (
      .clk   (clk),
      .wen   (wen),
      .wadd  (wadd),
      .wdata (wdata),
      .radd  (radd),
      .rdata (rdata)
   );

   fifo_rdctl #(.ADDW(ADDW), .DATW(DATW), .DELAY(DELAY)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .wptr     (wptr),
      .rptr     (rptr),
      .radd     (radd),
      .rdata    (rdata),
      .dout     (dout),
      .dout_vld (dout_vld),
      .dout_rdy (dout_rdy),
      .empty    (empty)
   );

   always @(posedge clk) begin
      if (rst_n && !clr) begin
         assert (5'(wptr - rptr) <= 5'd16)
            else $error("wptr moved backwards relative to rptr");
         assert (dut.obcnt <= 2'd3)
            else $error("output buffer overflow");
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; clr = 1'b0; wen = 1'b0; wptr = '0; dout_rdy = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic mem_write(input logic [ADDW-1:0] a, input logic [DATW-1:0] d);
      wen = 1'b1; wadd = a; wdata = d;
      tick();
      wen = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int exp, first, last, vcount, k;
      logic [ADDW:0]   prev_rptr;
      logic [ADDW-1:0] prev_radd;
      logic [ADDW:0]   rptr_log[$];
      logic [ADDW-1:0] radd_log[$];
      int exp_rptr [4];
      int exp_radd [4];
      exp_rptr = '{31, 0, 1, 2};
      exp_radd = '{14, 15, 0, 1};

      // Reset state
      do_reset();
      #1;
      check("rst_rptr", rptr, 0);
      check("rst_radd", radd, 0);
      check("rst_dout", dout, 0);
      check("rst_vld", dout_vld, 0);
      check("rst_empty", empty, 1);

      // Single word
      wen = 1'b1; wadd = 4'd0; wdata = 8'hA5;
      tick();
      wen = 1'b0; wptr = 5'd1;
      #1;
      check("t1_radd_w1", radd, 0);
      check("t1_empty_w1", empty, 0);
      check("t1_vld_w1", dout_vld, 0);
      tick(); #1;
      check("t1_rptr_w2", rptr, 1);
      check("t1_vld_w2", dout_vld, 0);
      tick(); #1;
      check("t1_vld_w3", dout_vld, 1);
      check("t1_dout_w3", dout, 8'hA5);
      check("t1_empty_w3", empty, 0);
      dout_rdy = 1'b1;
      tick(); #1;
      check("t1_vld_w4", dout_vld, 0);
      check("t1_empty_w4", empty, 1);
      check("t1_rptr_w4", rptr, 1);

      // Streaming 16 words
      do_reset();
      dout_rdy = 1'b1; exp = 0; first = -1; last = -1;
      for (int c = 0; c < 30; c++) begin
         if (c < 16) begin wen = 1'b1; wadd = 4'(c); wdata = 8'(c); end
         else wen = 1'b0;
         #1;
         if (dout_vld) begin
            check("t2_data", dout, 32'(exp));
            exp++;
            if (first < 0) first = c;
            last = c;
         end
         tick();
         if (c < 16) wptr = 5'(c + 1);
      end
      check("t2_count", exp, 16);
      check("t2_gapless", last - first, 15);
      check("t2_rptr", rptr, 16);
      check("t2_empty", empty, 1);

      // Back-pressure
      do_reset();
      for (int c = 0; c < 18; c++) begin
         if (c < 8) begin wen = 1'b1; wadd = 4'(c); wdata = 8'(c); end
         else wen = 1'b0;
         #1;
         if (c >= 8) begin
            check("t3_hold_vld", dout_vld, 1);
            check("t3_hold_dout", dout, 0);
         end
         tick();
         if (c < 8) wptr = 5'(c + 1);
      end
      #1;
      check("t3_rptr", rptr, 3);
      dout_rdy = 1'b1; exp = 0; first = -1; last = -1;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) #1;
         if (dout_vld) begin
            check("t3_data", dout, 32'(exp));
            exp++;
            if (first < 0) first = c;
            last = c;
         end
         tick();
      end
      check("t3_count", exp, 8);
      check("t3_gapless", last - first, 7);
      check("t3_rptr_end", rptr, 8);

      // Pointer wrap
      do_reset();
      dout_rdy = 1'b1; wptr = 5'd30; clr = 1'b1;
      tick();
      clr = 1'b0;
      #1;
      check("t4_rptr_pre", rptr, 30);
      check("t4_radd_pre", radd, 14);
      check("t4_empty_pre", empty, 1);
      prev_rptr = rptr; prev_radd = radd; exp = 0;
      for (int c = 0; c < 12; c++) begin
         if (c < 4) begin wen = 1'b1; wadd = 4'(14 + c); wdata = 8'(8'hC0 + c); end
         else wen = 1'b0;
         #1;
         if (rptr != prev_rptr) begin
            rptr_log.push_back(rptr);
            radd_log.push_back(prev_radd);
         end
         prev_rptr = rptr; prev_radd = radd;
         if (dout_vld) begin
            check("t4_data", dout, 32'(8'hC0 + exp));
            exp++;
         end
         tick();
         if (c < 4) wptr = wptr + 1'b1;
      end
      check("t4_count", exp, 4);
      check("t4_steps", rptr_log.size(), 4);
      for (int i = 0; i < 4 && i < rptr_log.size(); i++) begin
         check("t4_rptr_seq", rptr_log[i], exp_rptr[i]);
         check("t4_radd_seq", radd_log[i], exp_radd[i]);
      end

      // Flush with a word in flight
      do_reset();
      for (int i = 0; i < 5; i++) mem_write(4'(i), 8'(8'h50 + i));
      wptr = 5'd5;
      tick();
      tick();
      tick();
      #1;
      check("t5_vld_pre", dout_vld, 1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      #1;
      check("t5_vld_post", dout_vld, 0);
      check("t5_rptr_post", rptr, 5);
      check("t5_empty_post", empty, 1);
      dout_rdy = 1'b1; vcount = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (dout_vld) vcount++;
      end
      check("t5_no_stale", vcount, 0);
      check("t5_rptr_end", rptr, 5);

      // Asynchronous reset mid-stream
      do_reset();
      mem_write(4'd0, 8'h3C);
      wptr = 5'd1;
      k = 0;
      while (!dout_vld && k < 10) begin
         tick();
         k++;
      end
      check("t6_vld_seen", dout_vld, 1);
      #3;
      rst_n = 1'b0; wptr = '0;
      #1;
      check("t6_vld_async", dout_vld, 0);
      check("t6_rptr_async", rptr, 0);
      check("t6_empty_async", empty, 1);
      tick();
      rst_n = 1'b1; dout_rdy = 1'b1; vcount = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (dout_vld) vcount++;
      end
      check("t6_no_spurious", vcount, 0);
      check("t6_empty_end", empty, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
